rdmap_hdr_dispatch: RTL and testbench

RDMAP_HDR_DISPATCH -- requirements
Module: rdmap_hdr_dispatch

---
 rtl/rdmap_pkg.sv | 49 ++++
 rtl/rdmap_ram_2p.sv | 45 ++++
 rtl/rdmap_send_counter.sv | 155 +++++++++++++++
 rtl/rdmap_hdr_dispatch.sv | 153 +++++++++++++++
 tb/tb_rdmap_hdr_dispatch.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rdmap_pkg.sv
// rdmap_pkg: definitions shared by the RDMAP header dispatch block.
// Contents:
//   - default field widths and field positions of the header
//   - opcode constants for the header control byte
//   - opcode class enum, plus a decode helper used by the dispatcher
//   - state enum for the send-counter sweep FSM
package rdmap_pkg;

  localparam int TID_W_DEF   = 8;
  localparam int CNT_W_DEF   = 3;
  localparam int HDR_W_DEF   = 56;
  localparam int QNUM_W_DEF  = 16;
  localparam int TID_LSB_DEF = 48;

  localparam logic [7:0] OP_SEND    = 8'h00;
  localparam logic [7:0] OP_REQ     = 8'h03;
  localparam logic [7:0] OP_RD_DONE = 8'h04;
  localparam logic [7:0] OP_WR_DONE = 8'h06;
  localparam logic [7:0] OP_ACK     = 8'h07;

  typedef enum logic [2:0] {
    OPK_SEND    = 3'd0,
    OPK_REQ     = 3'd1,
    OPK_ACK     = 3'd2,
    OPK_WR_DONE = 3'd3,
    OPK_RD_DONE = 3'd4,
    OPK_UNKNOWN = 3'd5
  } opKind_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrState_e;

  // Map the raw control byte onto an opcode class; anything unlisted is unknown.
  function automatic opKind_e decodeOp(input logic [7:0] op);
    opKind_e kind;
    case (op)
      OP_SEND:    kind = OPK_SEND;
      OP_REQ:     kind = OPK_REQ;
      OP_ACK:     kind = OPK_ACK;
      OP_WR_DONE: kind = OPK_WR_DONE;
      OP_RD_DONE: kind = OPK_RD_DONE;
      default:    kind = OPK_UNKNOWN;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/rdmap_ram_2p.sv
// rdmap_ram_2p: generic simple dual-port RAM, one write port, one read port.
// The read has one cycle of latency. WRITE_FIRST selects what a read returns
// when it hits the address being written in the same cycle: the new data (1)
// or the old contents (0).
// Ports:
//   clock          - sole clock
//   wrEn/wrAddr/wrData - write port
//   rdEn/rdAddr    - read request; rdData is valid the cycle after rdEn
module rdmap_ram_2p #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter bit WRITE_FIRST = 1'b0
) (
  input  logic              clock,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array write.
  always_ff @(posedge clock) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Registered read, with optional forwarding of a colliding write.
  always_ff @(posedge clock) begin
    if (rdEn) begin
      if (WRITE_FIRST && wrEn && (wrAddr == rdAddr)) begin
        rdData <= wrData;
      end else begin
        rdData <= mem[rdAddr];
      end
    end
  end

endmodule

// File: rtl/rdmap_send_counter.sv
// rdmap_send_counter: per-TID count of SEND packets seen for the current message.
// After reset the whole table is swept to zero (INIT), then the block runs.
// A SEND accepted in cycle N reads the table; in cycle N+1 the stored count is
// incremented, compared with the expected count (0 means 1) and either written
// back or cleared on end-of-message. The table read is read-first, so a write
// in N+1 to the TID read in that same cycle is forwarded from a bypass register.
// Ports:
//   clock, reset          - clock, synchronous active-low reset
//   sendValid, sendTid    - SEND accepted this cycle and its TID
//   expCnt                - expected packet count, valid the cycle after sendValid
//   initDone              - sweep finished, block in RUN
//   eopValid, eopTid      - message-complete pulse and TID
module rdmap_send_counter
  import rdmap_pkg::*;
#(
  parameter int TID_W = TID_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sendValid,
  input  logic [TID_W-1:0] sendTid,
  input  logic [CNT_W-1:0] expCnt,
  output logic             initDone,
  output logic             eopValid,
  output logic [TID_W-1:0] eopTid
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [TID_W-1:0] TID_LAST = {TID_W{1'b1}};
  localparam logic [TID_W-1:0] TID_ZERO = {TID_W{1'b0}};

  ctrState_e        state_r;
  ctrState_e        stateNext_s;
  logic [TID_W-1:0] sweepAddr_r;
  logic             s1Valid_r;
  logic [TID_W-1:0] s1Tid_r;
  logic             byValid_r;
  logic [TID_W-1:0] byTid_r;
  logic [CNT_W-1:0] byData_r;
  logic [CNT_W-1:0] ramRdData_s;
  logic [CNT_W-1:0] stored_s;
  logic [CNT_W-1:0] sent_s;
  logic [CNT_W-1:0] expEff_s;
  logic [CNT_W-1:0] nextCnt_s;
  logic             eop_s;
  logic             ramWrEn_s;
  logic [TID_W-1:0] ramWrAddr_s;
  logic [CNT_W-1:0] ramWrData_s;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Sweep address: walks every entry once while in INIT.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sweepAddr_r <= TID_ZERO;
    end else if (state_r == ST_INIT) begin
      sweepAddr_r <= sweepAddr_r + {{(TID_W-1){1'b0}}, 1'b1};
    end
  end

  // Stage 1: remember which SEND is waiting for its table read.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1Valid_r <= 1'b0;
      s1Tid_r   <= TID_ZERO;
    end else begin
      s1Valid_r <= sendValid;
      s1Tid_r   <= sendTid;
    end
  end

  // Bypass register: copy of the write made in the same cycle as the next read.
  always_ff @(posedge clock) begin
    if (!reset) begin
      byValid_r <= 1'b0;
      byTid_r   <= TID_ZERO;
      byData_r  <= CNT_ZERO;
    end else begin
      byValid_r <= s1Valid_r;
      byTid_r   <= s1Tid_r;
      byData_r  <= ramWrData_s;
    end
  end

  // Count update: pick the freshest stored value and test for end of message.
  always_comb begin
    stored_s = ramRdData_s;
    if (byValid_r && (byTid_r == s1Tid_r)) begin
      stored_s = byData_r;
    end else begin
      stored_s = ramRdData_s;
    end
    sent_s    = stored_s + CNT_ONE;
    expEff_s  = (expCnt == CNT_ZERO) ? CNT_ONE : expCnt;
    eop_s     = (sent_s == expEff_s);
    nextCnt_s = eop_s ? CNT_ZERO : sent_s;
  end

  // Next state and table write port: sweep zeros in INIT, counts in RUN.
  always_comb begin
    stateNext_s = state_r;
    ramWrEn_s   = 1'b0;
    ramWrAddr_s = s1Tid_r;
    ramWrData_s = nextCnt_s;
    case (state_r)
      ST_INIT: begin
        ramWrEn_s   = 1'b1;
        ramWrAddr_s = sweepAddr_r;
        ramWrData_s = CNT_ZERO;
        if (sweepAddr_r == TID_LAST) begin
          stateNext_s = ST_RUN;
        end else begin
          stateNext_s = ST_INIT;
        end
      end
      ST_RUN: begin
        ramWrEn_s   = s1Valid_r;
        ramWrAddr_s = s1Tid_r;
        ramWrData_s = nextCnt_s;
        stateNext_s = ST_RUN;
      end
      default: begin
        stateNext_s = ST_INIT;
      end
    endcase
  end

  assign initDone = (state_r == ST_RUN);
  assign eopValid = s1Valid_r & eop_s & reset & (state_r == ST_RUN);
  assign eopTid   = s1Tid_r;

  rdmap_ram_2p #(
    .ADDR_W      (TID_W),
    .DATA_W      (CNT_W),
    .WRITE_FIRST (1'b0)
  ) uCountRam (
    .clock  (clock),
    .wrEn   (ramWrEn_s),
    .wrAddr (ramWrAddr_s),
    .wrData (ramWrData_s),
    .rdEn   (sendValid),
    .rdAddr (sendTid),
    .rdData (ramRdData_s)
  );

endmodule

// File: rtl/rdmap_hdr_dispatch.sv
// rdmap_hdr_dispatch: decodes incoming RDMAP headers and routes them.
//   SEND    - SOP pushes the TID to the offload FIFO; every SEND updates the
//             per-TID packet count and may signal message complete.
//   REQ     - forwarded on the request path (reqValid/reqInfo).
//   ACK     - pushes {tid, queue} to the ack FIFO and records the queue number.
//   WR_DONE / RD_DONE - push the TID to the matching done FIFO.
//   unknown - dropped and counted (saturating).
// Nothing is accepted until the count-table sweep after reset has finished.
// Ports:
//   clock, reset (sync, active-low); hdr* header handshake; *Fifo* FIFO pushes
//   and full flags; req* request path; dataNumRd* expected-count table read;
//   queueNumRd* queue-table read; sendEop* message complete; initDone;
//   badOpcodeCnt.
module rdmap_hdr_dispatch
  import rdmap_pkg::*;
#(
  parameter int TID_W   = TID_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int HDR_W   = HDR_W_DEF,
  parameter int QNUM_W  = QNUM_W_DEF,
  parameter int TID_LSB = TID_LSB_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    hdrValid,
  output logic                    hdrReady,
  input  logic [7:0]              hdrControl,
  input  logic [HDR_W-1:0]        hdrHeader,
  input  logic                    hdrIsSendSop,
  output logic                    ackFifoPush,
  output logic [TID_W+QNUM_W-1:0] ackFifoDataIn,
  input  logic                    ackFifoFull,
  output logic                    offloadFifoPush,
  output logic [TID_W-1:0]        offloadFifoDataIn,
  input  logic                    offloadFifoFull,
  output logic                    wrDoneFifoPush,
  output logic [TID_W-1:0]        wrDoneFifoDataIn,
  input  logic                    wrDoneFifoFull,
  output logic                    rdDoneFifoPush,
  output logic [TID_W-1:0]        rdDoneFifoDataIn,
  input  logic                    rdDoneFifoFull,
  output logic                    reqValid,
  input  logic                    reqReady,
  output logic [HDR_W-1:0]        reqInfo,
  output logic                    dataNumRd,
  output logic [TID_W-1:0]        dataNumRdAddr,
  input  logic [CNT_W-1:0]        dataNumRdData,
  input  logic                    queueNumRd,
  input  logic [TID_W-1:0]        queueNumRdAddr,
  output logic [QNUM_W-1:0]       queueNumRdData,
  output logic                    sendEopValid,
  output logic [TID_W-1:0]        sendEopTid,
  output logic                    initDone,
  output logic [15:0]             badOpcodeCnt
);

  logic [TID_W-1:0] tid_s;
  opKind_e          opKind_s;
  logic             ctrInitDone_s;
  logic             runEn_s;
  logic             hdrReady_s;
  logic             accept_s;
  logic             sendAccept_s;
  logic             ackAccept_s;
  logic [15:0]      badOpcodeCnt_r;

  assign tid_s    = hdrHeader[TID_LSB +: TID_W];
  assign opKind_s = decodeOp(hdrControl);

  // Reset is folded in so nothing is offered or pushed while it is held.
  assign runEn_s  = ctrInitDone_s & reset;
  assign initDone = runEn_s;

  // Ready: back-pressure only from the destination this opcode targets.
  always_comb begin
    hdrReady_s = 1'b0;
    if (runEn_s) begin
      case (opKind_s)
        OPK_SEND:    hdrReady_s = hdrIsSendSop ? ~offloadFifoFull : 1'b1;
        OPK_REQ:     hdrReady_s = reqReady;
        OPK_ACK:     hdrReady_s = ~ackFifoFull;
        OPK_WR_DONE: hdrReady_s = ~wrDoneFifoFull;
        OPK_RD_DONE: hdrReady_s = ~rdDoneFifoFull;
        default:     hdrReady_s = 1'b1;
      endcase
    end else begin
      hdrReady_s = 1'b0;
    end
  end

  assign hdrReady     = hdrReady_s;
  assign accept_s     = hdrValid & hdrReady_s;
  assign sendAccept_s = accept_s & (opKind_s == OPK_SEND);
  assign ackAccept_s  = accept_s & (opKind_s == OPK_ACK);

  assign ackFifoPush       = ackAccept_s;
  assign ackFifoDataIn     = {tid_s, hdrHeader[QNUM_W-1:0]};
  assign offloadFifoPush   = sendAccept_s & hdrIsSendSop;
  assign offloadFifoDataIn = tid_s;
  assign wrDoneFifoPush    = accept_s & (opKind_s == OPK_WR_DONE);
  assign wrDoneFifoDataIn  = tid_s;
  assign rdDoneFifoPush    = accept_s & (opKind_s == OPK_RD_DONE);
  assign rdDoneFifoDataIn  = tid_s;

  // The request path carries its own handshake; reqValid does not wait on reqReady.
  assign reqValid = hdrValid & (opKind_s == OPK_REQ) & runEn_s;
  assign reqInfo  = hdrHeader;

  assign dataNumRd     = sendAccept_s;
  assign dataNumRdAddr = tid_s;

  // Saturating count of dropped unknown-opcode headers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      badOpcodeCnt_r <= 16'h0000;
    end else if (accept_s && (opKind_s == OPK_UNKNOWN) && (badOpcodeCnt_r != 16'hFFFF)) begin
      badOpcodeCnt_r <= badOpcodeCnt_r + 16'h0001;
    end
  end

  assign badOpcodeCnt = badOpcodeCnt_r;

  rdmap_send_counter #(
    .TID_W (TID_W),
    .CNT_W (CNT_W)
  ) uSendCounter (
    .clock     (clock),
    .reset     (reset),
    .sendValid (sendAccept_s),
    .sendTid   (tid_s),
    .expCnt    (dataNumRdData),
    .initDone  (ctrInitDone_s),
    .eopValid  (sendEopValid),
    .eopTid    (sendEopTid)
  );

  // Queue-number table: written by ACKs, read externally; a same-cycle
  // read of the TID being written returns the new queue number.
  rdmap_ram_2p #(
    .ADDR_W      (TID_W),
    .DATA_W      (QNUM_W),
    .WRITE_FIRST (1'b1)
  ) uQueueRam (
    .clock  (clock),
    .wrEn   (ackAccept_s),
    .wrAddr (tid_s),
    .wrData (hdrHeader[QNUM_W-1:0]),
    .rdEn   (queueNumRd),
    .rdAddr (queueNumRdAddr),
    .rdData (queueNumRdData)
  );

endmodule

// File: tb/tb_rdmap_hdr_dispatch.sv
// tb_rdmap_hdr_dispatch: directed self-checking bench for rdmap_hdr_dispatch.
// Inputs are driven on the falling edge; combinational outputs are checked
// 1ns later, registered results 1ns after the rising edge.
module tb_rdmap_hdr_dispatch;

  logic        clock = 1'b0;
  logic        reset;
  logic        hdrValid;
  logic        hdrReady;
  logic [7:0]  hdrControl;
  logic [55:0] hdrHeader;
  logic        hdrIsSendSop;
  logic        ackFifoPush;
  logic [23:0] ackFifoDataIn;
  logic        ackFifoFull;
  logic        offloadFifoPush;
  logic [7:0]  offloadFifoDataIn;
  logic        offloadFifoFull;
  logic        wrDoneFifoPush;
  logic [7:0]  wrDoneFifoDataIn;
  logic        wrDoneFifoFull;
  logic        rdDoneFifoPush;
  logic [7:0]  rdDoneFifoDataIn;
  logic        rdDoneFifoFull;
  logic        reqValid;
  logic        reqReady;
  logic [55:0] reqInfo;
  logic        dataNumRd;
  logic [7:0]  dataNumRdAddr;
  logic [2:0]  dataNumRdData;
  logic        queueNumRd;
  logic [7:0]  queueNumRdAddr;
  logic [15:0] queueNumRdData;
  logic        sendEopValid;
  logic [7:0]  sendEopTid;
  logic        initDone;
  logic [15:0] badOpcodeCnt;

  int          checkCnt = 0;
  int          errCnt   = 0;
  logic [2:0]  expSetting;

  always #5 clock = ~clock;

  rdmap_hdr_dispatch dut (
    .clock             (clock),
    .reset             (reset),
    .hdrValid          (hdrValid),
    .hdrReady          (hdrReady),
    .hdrControl        (hdrControl),
    .hdrHeader         (hdrHeader),
    .hdrIsSendSop      (hdrIsSendSop),
    .ackFifoPush       (ackFifoPush),
    .ackFifoDataIn     (ackFifoDataIn),
    .ackFifoFull       (ackFifoFull),
    .offloadFifoPush   (offloadFifoPush),
    .offloadFifoDataIn (offloadFifoDataIn),
    .offloadFifoFull   (offloadFifoFull),
    .wrDoneFifoPush    (wrDoneFifoPush),
    .wrDoneFifoDataIn  (wrDoneFifoDataIn),
    .wrDoneFifoFull    (wrDoneFifoFull),
    .rdDoneFifoPush    (rdDoneFifoPush),
    .rdDoneFifoDataIn  (rdDoneFifoDataIn),
    .rdDoneFifoFull    (rdDoneFifoFull),
    .reqValid          (reqValid),
    .reqReady          (reqReady),
    .reqInfo           (reqInfo),
    .dataNumRd         (dataNumRd),
    .dataNumRdAddr     (dataNumRdAddr),
    .dataNumRdData     (dataNumRdData),
    .queueNumRd        (queueNumRd),
    .queueNumRdAddr    (queueNumRdAddr),
    .queueNumRdData    (queueNumRdData),
    .sendEopValid      (sendEopValid),
    .sendEopTid        (sendEopTid),
    .initDone          (initDone),
    .badOpcodeCnt      (badOpcodeCnt)
  );

  // Expected-count table model: every TID reads back expSetting, one cycle later.
  always @(posedge clock) begin
    if (dataNumRd) dataNumRdData <= expSetting;
  end

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hdrValid     = 1'b0;
    hdrControl   = 8'hFF;
    hdrHeader    = 56'h0;
    hdrIsSendSop = 1'b0;
  endtask

  task automatic drive(input logic [7:0] op, input logic [7:0] tid,
                       input logic [15:0] low, input logic sop);
    hdrValid     = 1'b1;
    hdrControl   = op;
    hdrHeader    = {tid, 32'h0000_0000, low};
    hdrIsSendSop = sop;
  endtask

  function automatic logic anyPush();
    return ackFifoPush | offloadFifoPush | wrDoneFifoPush | rdDoneFifoPush | reqValid | sendEopValid;
  endfunction

  // Counts rising edges until initDone, bounded; also watches for early activity.
  task automatic waitInit(input string tag);
    int   cycles;
    logic early;
    cycles = 0;
    early  = 1'b0;
    while (!initDone && cycles < 1000) begin
      @(posedge clock);
      #1;
      cycles++;
      if (!initDone && (hdrReady || anyPush())) early = 1'b1;
    end
    checkEq({tag, "_init_cycles"}, cycles, 256);
    checkEq({tag, "_ready_early"}, early, 1'b0);
  endtask

  // One SEND with an idle cycle after it; checks the N+1 write and EOP.
  task automatic sendOne(input string tag, input logic [7:0] tid, input logic sop,
                         input logic [2:0] expWr, input logic expEop);
    @(negedge clock);
    drive(8'h00, tid, 16'h0000, sop);
    #1;
    checkEq({tag, "_ready"}, hdrReady, 1'b1);
    @(posedge clock);
    #1;
    checkEq({tag, "_wrEn"}, dut.uSendCounter.ramWrEn_s, 1'b1);
    checkEq({tag, "_stored"}, dut.uSendCounter.ramWrData_s, expWr);
    checkEq({tag, "_eop"}, sendEopValid, expEop);
    if (expEop) checkEq({tag, "_eopTid"}, sendEopTid, tid);
    @(negedge clock);
    idle();
  endtask

  int expSeq [3] = '{1, 2, 0};

  initial begin
    reset = 1'b0;
    idle();
    ackFifoFull = 1'b0; offloadFifoFull = 1'b0; wrDoneFifoFull = 1'b0; rdDoneFifoFull = 1'b0;
    reqReady = 1'b1; queueNumRd = 1'b0; queueNumRdAddr = 8'h00;
    dataNumRdData = 3'd0; expSetting = 3'd3;

    // Reset state: nothing offered, nothing pushed.
    repeat (3) @(negedge clock);
    drive(8'h03, 8'h05, 16'h1234, 1'b0);
    #1;
    checkEq("rst_initDone", initDone, 1'b0);
    checkEq("rst_ready", hdrReady, 1'b0);
    checkEq("rst_reqValid", reqValid, 1'b0);
    checkEq("rst_badCnt", badOpcodeCnt, 16'h0);
    checkEq("rst_push", anyPush(), 1'b0);

    // Sweep after release, with an unknown opcode held valid throughout.
    @(negedge clock);
    reset = 1'b1;
    drive(8'h0F, 8'h00, 16'h0000, 1'b0);
    waitInit("rel");
    checkEq("init_badCnt", badOpcodeCnt, 16'h0);
    @(negedge clock);
    idle();

    // Three back-to-back SENDs on TID 5, expected 3: stores 1,2,0 via bypass.
    expSetting = 3'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(8'h00, 8'h05, 16'h0000, (i == 0));
      #1;
      checkEq("b2b_ready", hdrReady, 1'b1);
      checkEq("b2b_dnRd", dataNumRd, 1'b1);
      checkEq("b2b_dnAddr", dataNumRdAddr, 8'h05);
      checkEq("b2b_offPush", offloadFifoPush, (i == 0));
      @(posedge clock);
      #1;
      checkEq("b2b_stored", dut.uSendCounter.ramWrData_s, expSeq[i]);
      checkEq("b2b_eop", sendEopValid, (i == 2));
      if (i == 2) checkEq("b2b_eopTid", sendEopTid, 8'h05);
    end
    @(negedge clock);
    idle();

    // Expected 0 behaves as 1; expected 2 across a gap uses the RAM path.
    expSetting = 3'd0;
    sendOne("exp0", 8'h07, 1'b1, 3'd0, 1'b1);
    expSetting = 3'd2;
    sendOne("exp2a", 8'h09, 1'b1, 3'd1, 1'b0);
    sendOne("exp2b", 8'h09, 1'b0, 3'd0, 1'b1);

    // SOP SEND blocked by a full offload FIFO, then accepted when it drains.
    expSetting = 3'd3;
    @(negedge clock);
    offloadFifoFull = 1'b1;
    drive(8'h00, 8'h05, 16'h0000, 1'b1);
    #1;
    checkEq("offFull_ready", hdrReady, 1'b0);
    checkEq("offFull_push", offloadFifoPush, 1'b0);
    checkEq("offFull_dnRd", dataNumRd, 1'b0);
    @(posedge clock);
    #1;
    checkEq("offFull_noWr", dut.uSendCounter.ramWrEn_s, 1'b0);
    @(negedge clock);
    offloadFifoFull = 1'b0;
    #1;
    checkEq("offFree_ready", hdrReady, 1'b1);
    checkEq("offFree_push", offloadFifoPush, 1'b1);
    checkEq("offFree_data", offloadFifoDataIn, 8'h05);
    @(negedge clock);
    offloadFifoFull = 1'b1;
    drive(8'h00, 8'h05, 16'h0000, 1'b0);
    #1;
    checkEq("nonSop_ready", hdrReady, 1'b1);
    checkEq("nonSop_push", offloadFifoPush, 1'b0);
    @(negedge clock);
    offloadFifoFull = 1'b0;
    idle();

    // ACK: push {tid,queue}, then read the queue table on the next cycle.
    @(negedge clock);
    drive(8'h07, 8'h10, 16'hBEEF, 1'b0);
    #1;
    checkEq("ack_push", ackFifoPush, 1'b1);
    checkEq("ack_data", ackFifoDataIn, 24'h10BEEF);
    @(negedge clock);
    idle();
    queueNumRd = 1'b1;
    queueNumRdAddr = 8'h10;
    @(posedge clock);
    #1;
    checkEq("qtab_read", queueNumRdData, 16'hBEEF);
    @(negedge clock);
    drive(8'h07, 8'h20, 16'h1234, 1'b0);
    queueNumRdAddr = 8'h20;
    @(posedge clock);
    #1;
    checkEq("qtab_wrFirst", queueNumRdData, 16'h1234);
    @(negedge clock);
    idle();
    queueNumRd = 1'b0;
    ackFifoFull = 1'b1;
    drive(8'h07, 8'h30, 16'h5555, 1'b0);
    #1;
    checkEq("ackFull_ready", hdrReady, 1'b0);
    checkEq("ackFull_push", ackFifoPush, 1'b0);
    ackFifoFull = 1'b0;

    // REQ: valid regardless of reqReady; ready follows reqReady.
    reqReady = 1'b0;
    hdrValid = 1'b1; hdrControl = 8'h03; hdrHeader = 56'h12_3456_789A_BCDE; hdrIsSendSop = 1'b0;
    #1;
    checkEq("req_valid", reqValid, 1'b1);
    checkEq("req_info", reqInfo, 56'h12_3456_789A_BCDE);
    checkEq("req_notReady", hdrReady, 1'b0);
    reqReady = 1'b1;
    #1;
    checkEq("req_ready", hdrReady, 1'b1);

    // WR_DONE / RD_DONE pushes and back-pressure.
    @(negedge clock);
    drive(8'h06, 8'h33, 16'h0000, 1'b0);
    #1;
    checkEq("wrDone_push", wrDoneFifoPush, 1'b1);
    checkEq("wrDone_data", wrDoneFifoDataIn, 8'h33);
    wrDoneFifoFull = 1'b1;
    #1;
    checkEq("wrDoneFull_ready", hdrReady, 1'b0);
    wrDoneFifoFull = 1'b0;
    @(negedge clock);
    drive(8'h04, 8'h44, 16'h0000, 1'b0);
    #1;
    checkEq("rdDone_push", rdDoneFifoPush, 1'b1);
    checkEq("rdDone_data", rdDoneFifoDataIn, 8'h44);
    checkEq("rdDone_noWr", wrDoneFifoPush, 1'b0);
    @(negedge clock);
    idle();

    // Unknown opcode: counted, never pushed, saturates at 0xFFFF.
    @(negedge clock);
    drive(8'h0F, 8'h01, 16'h0000, 1'b0);
    #1;
    checkEq("bad_ready", hdrReady, 1'b1);
    checkEq("bad_push", anyPush(), 1'b0);
    repeat (3) @(posedge clock);
    #1;
    checkEq("bad_cnt3", badOpcodeCnt, 16'd3);
    repeat (65532) @(posedge clock);
    #1;
    checkEq("bad_cntMax", badOpcodeCnt, 16'hFFFF);
    repeat (2) @(posedge clock);
    #1;
    checkEq("bad_cntHold", badOpcodeCnt, 16'hFFFF);
    @(negedge clock);
    idle();

    // Reset between the 1st and 2nd SEND of a message on TID 5.
    // TID 5 holds 2 here, so the first SEND completes that message.
    expSetting = 3'd3;
    sendOne("pre_done", 8'h05, 1'b1, 3'd0, 1'b1);
    sendOne("pre_first", 8'h05, 1'b1, 3'd1, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    drive(8'h00, 8'h05, 16'h0000, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    checkEq("mid_initDone", initDone, 1'b0);
    checkEq("mid_ready", hdrReady, 1'b0);
    checkEq("mid_badCnt", badOpcodeCnt, 16'h0);
    checkEq("mid_push", anyPush(), 1'b0);
    @(negedge clock);
    idle();
    reset = 1'b1;
    waitInit("mid");
    sendOne("post_first", 8'h05, 1'b0, 3'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule
